// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: load-use stalls, branch flushes, data-memory freeze
// with timeout, plus saturating stall/flush counters.
module hazard_control_unit #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_mem_read,
    input  logic             EX_branch_taken,
    input  logic             MEM_mem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] TO_V = WW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t            r_state, w_next;
    logic [WW-1:0]     r_cnt, w_cnt_next;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_stall, r_flush;
    logic              w_freeze, w_load_use, w_branch;

    always_comb begin
        w_freeze = 1'b0;
        case (r_state)
            RUN:      w_freeze = MEM_mem_req && !dmem_ready;
            MEM_WAIT: w_freeze = !dmem_ready;
            default:  w_freeze = 1'b1;
        endcase
    end

    assign w_load_use = EX_mem_read && (EX_rd != 5'd0) &&
                        ((ID_uses_rs1 && ID_rs1 == EX_rd) ||
                         (ID_uses_rs2 && ID_rs2 == EX_rd));
    assign w_branch = !w_freeze && EX_branch_taken;

    // Branch outranks load-use: the dependent instruction gets squashed anyway.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_flush   = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        if (w_freeze) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (EX_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            RUN: begin
                if (w_freeze) begin
                    w_next     = MEM_WAIT;
                    w_cnt_next = WW'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    w_next     = RUN;
                    w_cnt_next = '0;
                end else if (r_cnt == TO_V) begin
                    w_next = FAULT;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_next = FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_stall   <= '0;
            r_flush   <= '0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_timeout <= r_timeout || (w_next == FAULT);
            if (!pc_write && r_stall != '1)
                r_stall <= r_stall + 1'b1;
            if (w_branch && r_flush != '1)
                r_flush <= r_flush + 1'b1;
        end
    end

    assign mem_timeout  = r_timeout;
    assign stall_cycles = r_stall;
    assign flush_count  = r_flush;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with an in-bench reference model
// compared every cycle, plus hand-computed literal checks.
module tb_hazard_control_unit;

    localparam int T    = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    ID_rs1, ID_rs2, EX_rd;
    logic          ID_uses_rs1, ID_uses_rs2, EX_mem_read;
    logic          EX_branch_taken, MEM_mem_req, dmem_ready;
    logic          pc_write, ifid_write, ifid_flush, idex_write;
    logic          idex_flush, exmem_write, memwb_bubble, mem_timeout;
    logic [CW-1:0] stall_cycles, flush_count;

    int checks = 0;
    int failures = 0;

    hazard_control_unit #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .EX_rd(EX_rd), .EX_mem_read(EX_mem_read),
        .EX_branch_taken(EX_branch_taken),
        .MEM_mem_req(MEM_mem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_write(idex_write),
        .idex_flush(idex_flush), .exmem_write(exmem_write),
        .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Model: fault flag, length of the current unserved memory-wait streak,
    // and plain integer counters clipped at the maximum.
    bit m_fault;
    int m_streak, m_stall, m_flush;

    function automatic bit m_frozen();
        return m_fault || (!dmem_ready && (m_streak > 0 || MEM_mem_req));
    endfunction

    function automatic bit m_lu();
        return EX_mem_read && EX_rd != 0 &&
               ((ID_uses_rs1 && ID_rs1 == EX_rd) ||
                (ID_uses_rs2 && ID_rs2 == EX_rd));
    endfunction

    // {pc, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_b}
    function automatic logic [6:0] m_ctrl();
        if (m_frozen())           return 7'b0000001;
        else if (EX_branch_taken) return 7'b1111110;
        else if (m_lu())          return 7'b0001110;
        else                      return 7'b1101010;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fault  = 0;
            m_streak = 0;
            m_stall  = 0;
            m_flush  = 0;
        end else begin
            logic [6:0] c;
            c = m_ctrl();
            if (!c[6] && m_stall < CMAX) m_stall++;
            if (!m_frozen() && EX_branch_taken && m_flush < CMAX) m_flush++;
            if (!m_fault) begin
                if (m_frozen()) m_streak++;
                else            m_streak = 0;
                if (m_streak == T + 1) m_fault = 1;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_ctrl", {pc_write, ifid_write, ifid_flush, idex_write,
                               idex_flush, exmem_write, memwb_bubble}, m_ctrl());
            chk("model_timeout", mem_timeout, m_fault);
            chk("model_stall", stall_cycles, m_stall);
            chk("model_flush", flush_count, m_flush);
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ID_rs1 = 0; ID_rs2 = 0; EX_rd = 0;
        ID_uses_rs1 = 0; ID_uses_rs2 = 0; EX_mem_read = 0;
        EX_branch_taken = 0; MEM_mem_req = 0; dmem_ready = 0;
    endtask

    task automatic load_use5();
        EX_mem_read = 1; EX_rd = 5;
        ID_rs1 = 3; ID_uses_rs1 = 1;
        ID_rs2 = 5; ID_uses_rs2 = 1;
    endtask

    initial begin
        idle();
        #12;
        chk("rst_pc", pc_write, 1);
        chk("rst_bubble", memwb_bubble, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_timeout", mem_timeout, 0);
        rst_n = 1;
        go();

        load_use5();
        @(negedge clk);
        chk("lu_pc", pc_write, 0);
        chk("lu_ifid_w", ifid_write, 0);
        chk("lu_idex_f", idex_flush, 1);
        go(); idle();
        chk("lu_stall", stall_cycles, 1);

        EX_mem_read = 1; EX_rd = 0; ID_rs1 = 0; ID_uses_rs1 = 1;
        @(negedge clk);
        chk("x0_pc", pc_write, 1);
        chk("x0_idex_f", idex_flush, 0);
        go(); idle();

        EX_mem_read = 1; EX_rd = 7; ID_rs1 = 7; ID_rs2 = 7;
        @(negedge clk);
        chk("nouse_pc", pc_write, 1);
        ID_uses_rs1 = 1;
        #1 chk("rs1_pc", pc_write, 0);
        go(); idle();

        load_use5(); EX_branch_taken = 1;
        @(negedge clk);
        chk("br_pc", pc_write, 1);
        chk("br_ifid_f", ifid_flush, 1);
        chk("br_idex_f", idex_flush, 1);
        go(); idle();
        chk("br_flush", flush_count, 1);
        chk("br_stall", stall_cycles, 2);

        MEM_mem_req = 1;
        @(negedge clk);
        chk("fz_pc", pc_write, 0);
        chk("fz_bubble", memwb_bubble, 1);
        go(); EX_branch_taken = 1;
        @(negedge clk);
        chk("fz_br_ign", ifid_flush, 0);
        go(); EX_branch_taken = 0;
        go(); dmem_ready = 1; EX_branch_taken = 1;
        @(negedge clk);
        chk("rel_pc", pc_write, 1);
        chk("rel_ifid_f", ifid_flush, 1);
        go(); idle();
        chk("rel_stall", stall_cycles, 5);
        chk("rel_flush", flush_count, 2);
        @(negedge clk);
        chk("rel_run", pc_write, 1);

        go(); MEM_mem_req = 1;
        repeat (4) go();
        chk("to_pre", mem_timeout, 0);
        go();
        chk("to_set", mem_timeout, 1);
        dmem_ready = 1; MEM_mem_req = 0;
        @(negedge clk);
        chk("fault_pc", pc_write, 0);
        repeat (20) go();
        chk("stall_sat", stall_cycles, CMAX);
        #1 rst_n = 0;
        #1;
        chk("frst_timeout", mem_timeout, 0);
        chk("frst_stall", stall_cycles, 0);
        chk("frst_pc", pc_write, 1);
        idle();
        @(negedge clk); #1 rst_n = 1;

        go(); EX_branch_taken = 1;
        repeat (17) go();
        chk("flush_sat", flush_count, CMAX);
        idle();

        MEM_mem_req = 1;
        go(); go();
        #1 rst_n = 0;
        #2 rst_n = 1;
        MEM_mem_req = 0;
        @(negedge clk);
        chk("mrst_run", pc_write, 1);
        go(); go();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
